wb_decoder: RTL and testbench

WB_DECODER -- requirements
Module: wb_decoder

---
 rtl/wb_decoder.sv | 147 ++++++++++++++
 tb/tb_wb_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_decoder.sv
// Wishbone single-master to N-slave address decoder with per-slave base offsetting.
// Optional response watchdog is enabled by defining WB_DECODER_TIMEOUT_EN.
module wb_decoder #(
  parameter int N_SLAVES = 6,
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int SEL_W    = 2,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = {24'h050000, 24'h040000, 24'h030000,
                                                    24'h020000, 24'h010000, 24'h002000},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_END  = {24'h05FFFF, 24'h04FFFF, 24'h03FFFF,
                                                    24'h02FFFF, 24'h01FFFF, 24'h002003},
  parameter int TIMEOUT  = 255
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         m_cyc,
  input  logic                         m_stb,
  input  logic                         m_we,
  input  logic [ADDR_W-1:0]            m_adr,
  input  logic [SEL_W-1:0]             m_sel,
  input  logic [DATA_W-1:0]            m_i_dat,
  output logic [DATA_W-1:0]            m_o_dat,
  output logic                         m_ack,
  output logic                         m_err,
  output logic [N_SLAVES-1:0]          s_cyc,
  output logic [N_SLAVES-1:0]          s_stb,
  output logic [N_SLAVES*ADDR_W-1:0]   s_adr,
  output logic                         s_we,
  output logic [SEL_W-1:0]             s_sel,
  output logic [DATA_W-1:0]            s_o_dat,
  input  logic [N_SLAVES*DATA_W-1:0]   s_i_dat,
  input  logic [N_SLAVES-1:0]          s_ack,
  input  logic [N_SLAVES-1:0]          s_err
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] sel_q, dec_idx;
  logic             dec_hit;
  logic             set_ack, set_err, load_dat;
  logic             expired;

  assign s_we    = m_we;
  assign s_sel   = m_sel;
  assign s_o_dat = m_i_dat;

  for (genvar k = 0; k < N_SLAVES; k++) begin : g_adr
    assign s_adr[k*ADDR_W +: ADDR_W] = m_adr - SLV_BASE[k*ADDR_W +: ADDR_W];
  end

  // Descending scan so the lowest matching window is the last one written.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if (m_adr >= SLV_BASE[k*ADDR_W +: ADDR_W] && m_adr <= SLV_END[k*ADDR_W +: ADDR_W]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(k);
      end
    end
  end

`ifdef WB_DECODER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  logic [CNT_W-1:0] cnt;

  // Fires on the ACTIVE cycle whose increment would bring the count to TIMEOUT.
  assign expired = (cnt + CNT_W'(1)) == CNT_W'(TIMEOUT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (state != ACTIVE && next_state == ACTIVE) begin
      cnt <= '0;
    end else if (state == ACTIVE) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    next_state = state;
    set_ack    = 1'b0;
    set_err    = 1'b0;
    load_dat   = 1'b0;
    s_cyc      = '0;
    s_stb      = '0;
    case (state)
      IDLE: begin
        if (m_cyc && m_stb) begin
          if (dec_hit) begin
            next_state = ACTIVE;
          end else begin
            next_state = RESP;
            set_err    = 1'b1;
          end
        end
      end
      ACTIVE: begin
        s_cyc[sel_q] = m_cyc;
        s_stb[sel_q] = m_stb;
        if (!m_cyc) begin
          next_state = IDLE;
        end else if (s_err[sel_q]) begin
          next_state = RESP;
          set_err    = 1'b1;
        end else if (s_ack[sel_q]) begin
          next_state = RESP;
          set_ack    = 1'b1;
          load_dat   = 1'b1;
        end else if (expired) begin
          next_state = RESP;
          set_err    = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered state and master-side response
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      sel_q   <= '0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_o_dat <= '0;
    end else begin
      state <= next_state;
      m_ack <= set_ack;
      m_err <= set_err;
      if (state == IDLE && m_cyc && m_stb && dec_hit) begin
        sel_q <= dec_idx;
      end
      if (load_dat) begin
        m_o_dat <= s_i_dat[sel_q*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_wb_decoder.sv
// Scoreboard bench for wb_decoder: stimulus queues expected master responses,
// a negedge monitor pops and compares them whenever m_ack or m_err is seen.
module tb_wb_decoder;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int SW = 2;

  logic            clk, rst;
  logic            m_cyc, m_stb, m_we;
  logic [AW-1:0]   m_adr;
  logic [SW-1:0]   m_sel;
  logic [DW-1:0]   m_i_dat, m_o_dat;
  logic            m_ack, m_err;
  logic [N-1:0]    s_cyc, s_stb, s_ack, s_err;
  logic [N*AW-1:0] s_adr;
  logic            s_we;
  logic [SW-1:0]   s_sel;
  logic [DW-1:0]   s_o_dat;
  logic [N*DW-1:0] s_i_dat;

  typedef struct packed {
    logic          ack;
    logic          err;
    logic [DW-1:0] dat;
  } resp_t;

  resp_t sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  wb_decoder #(
    .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW),
    .SLV_BASE({24'h0F0000, 24'h200000, 24'h100000, 24'h002000}),
    .SLV_END ({24'h1FFFFF, 24'h2000FF, 24'h10FFFF, 24'h002003}),
    .TIMEOUT(4)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_adr(m_adr), .m_sel(m_sel), .m_i_dat(m_i_dat),
    .m_o_dat(m_o_dat), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_adr(s_adr),
    .s_we(s_we), .s_sel(s_sel), .s_o_dat(s_o_dat),
    .s_i_dat(s_i_dat), .s_ack(s_ack), .s_err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] sadr(input int k);
    return s_adr[k*AW +: AW];
  endfunction

  task automatic set_slv(input int k, input logic ack, input logic err, input logic [DW-1:0] dat);
    s_ack[k]          = ack;
    s_err[k]          = err;
    s_i_dat[k*DW +: DW] = dat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat);
    m_cyc   = 1'b1;
    m_stb   = 1'b1;
    m_we    = we;
    m_adr   = adr;
    m_sel   = 2'b11;
    m_i_dat = dat;
  endtask

  task automatic idle_master();
    m_cyc = 1'b0;
    m_stb = 1'b0;
    m_we  = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    resp_t e;
    if (!rst && (m_ack || m_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", {30'd0, m_ack, m_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("mon_ack", m_ack, e.ack);
        check("mon_err", m_err, e.err);
        check("mon_dat", m_o_dat, e.dat);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    rst = 1'b1;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    m_adr = '0; m_sel = '0; m_i_dat = '0;
    s_i_dat = '0; s_ack = '0; s_err = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", m_ack, 0);
    check("rst_err", m_err, 0);
    check("rst_dat", m_o_dat, 0);
    check("rst_stb", s_stb, 0);
    check("rst_cyc", s_cyc, 0);
    rst = 1'b0;

    // Read from window 0 with next-cycle ack
    tick();
    req(24'h002001, 1'b0, 16'h0000);
    sb.push_back('{ack: 1'b1, err: 1'b0, dat: 16'hBEEF});
    @(negedge clk);
    check("rd_sadr0", sadr(0), 24'h000001);
    check("idle_no_stb", s_stb, 4'b0000);
    tick();
    check("rd_stb", s_stb, 4'b0001);
    check("rd_cyc", s_cyc, 4'b0001);
    set_slv(0, 1'b1, 1'b0, 16'hBEEF);
    tick();
    check("latency_ack", m_ack, 1);
    check("resp_no_stb", s_stb, 4'b0000);
    set_slv(0, 1'b0, 1'b0, 16'h0000);
    idle_master();
    tick();
    check("ack_one_cycle", m_ack, 0);

    // Write to unmapped address
    req(24'h000500, 1'b1, 16'h5555);
    sb.push_back('{ack: 1'b0, err: 1'b1, dat: 16'hBEEF});
    #1;
    check("pass_we", s_we, 1);
    check("pass_dat", s_o_dat, 16'h5555);
    tick();
    check("unmapped_no_stb", s_stb, 4'b0000);
    check("unmapped_err", m_err, 1);
    idle_master();
    tick();
    check("err_one_cycle", m_err, 0);

    // Overlapping windows 1 and 3; stray ack from 3; simultaneous ack+err on 1
    req(24'h100000, 1'b0, 16'h0000);
    tick();
    check("ovl_stb", s_stb, 4'b0010);
    check("ovl_sadr1", sadr(1), 24'h000000);
    check("ovl_sadr3", sadr(3), 24'h010000);
    set_slv(3, 1'b1, 1'b0, 16'h1111);
    tick();
    check("nonsel_ack_ignored", s_stb, 4'b0010);
    set_slv(3, 1'b0, 1'b0, 16'h0000);
    set_slv(1, 1'b1, 1'b1, 16'h2222);
    sb.push_back('{ack: 1'b0, err: 1'b1, dat: 16'hBEEF});
    tick();
    set_slv(1, 1'b0, 1'b0, 16'h0000);
    idle_master();
    tick();

    // Read from slave 2 updates m_o_dat
    req(24'h200010, 1'b0, 16'h0000);
    sb.push_back('{ack: 1'b1, err: 1'b0, dat: 16'h1234});
    tick();
    check("s2_sadr", sadr(2), 24'h000010);
    check("s2_stb", s_stb, 4'b0100);
    set_slv(2, 1'b1, 1'b0, 16'h1234);
    tick();
    set_slv(2, 1'b0, 1'b0, 16'h0000);
    idle_master();
    tick();

    // Master abort while ACTIVE
    req(24'h002002, 1'b0, 16'h0000);
    tick();
    check("abort_stb_pre", s_stb, 4'b0001);
    idle_master();
    #1;
    check("abort_cyc", s_cyc, 4'b0000);
    tick();
    check("abort_no_resp", {m_ack, m_err}, 2'b00);
    tick();

    // Unresponsive slave
    req(24'h200000, 1'b0, 16'h0000);
    tick();
`ifdef WB_DECODER_TIMEOUT_EN
    sb.push_back('{ack: 1'b0, err: 1'b1, dat: 16'h1234});
    repeat (3) tick();
    check("to_still_active", s_stb, 4'b0100);
    check("to_no_err_yet", m_err, 0);
    tick();
    check("to_err", m_err, 1);
    check("to_stb_drop", s_stb, 4'b0000);
    idle_master();
    tick();
`else
    repeat (100) tick();
    check("no_to_active", s_stb, 4'b0100);
    check("no_to_resp", {m_ack, m_err}, 2'b00);
    idle_master();
    tick();
    tick();
`endif

    // Asynchronous reset mid-transaction, then normal recovery
    req(24'h002000, 1'b0, 16'h0000);
    tick();
    check("prerst_stb", s_stb, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    check("arst_stb", s_stb, 4'b0000);
    check("arst_cyc", s_cyc, 4'b0000);
    check("arst_dat", m_o_dat, 0);
    check("arst_resp", {m_ack, m_err}, 2'b00);
    idle_master();
    #2;
    rst = 1'b0;
    tick();
    req(24'h002003, 1'b0, 16'h0000);
    sb.push_back('{ack: 1'b1, err: 1'b0, dat: 16'hCAFE});
    tick();
    check("post_rst_stb", s_stb, 4'b0001);
    check("post_rst_sadr", sadr(0), 24'h000003);
    set_slv(0, 1'b1, 1'b0, 16'hCAFE);
    tick();
    set_slv(0, 1'b0, 1'b0, 16'h0000);
    idle_master();
    repeat (3) tick();
    check("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
